// File: rtl/sap_pkg.sv
// sap_pkg -- shared definitions for the SAP-style datapath blocks
// (program counter, ALU, control sequencer).
// Contents:
//   OP_*       4-bit opcode values (upper nibble of the instruction register)
//   T1..T6     one-hot T-state encodings, bit0 = T1
//   CW_*       bit positions of the internal active-high control word
//   instr_e    decoded instruction class
//   decode_opcode()  opcode -> instruction class
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  // Control word is active high internally; the *_n pins are its inverse.
  localparam int CW_PC_INC  = 0;
  localparam int CW_PC_OUT  = 1;
  localparam int CW_RAM_OUT = 2;
  localparam int CW_IR_OUT  = 3;
  localparam int CW_A_OUT   = 4;
  localparam int CW_ALU_OUT = 5;
  localparam int CW_MAR_IN  = 6;
  localparam int CW_IR_IN   = 7;
  localparam int CW_A_IN    = 8;
  localparam int CW_B_IN    = 9;
  localparam int CW_OUT_IN  = 10;
  localparam int CW_ALU_SUB = 11;
  localparam int CW_W       = 12;

  typedef logic [CW_W-1:0] ctrl_word_t;

  typedef enum logic [2:0] {
    INSTR_LDA   = 3'd0,
    INSTR_ADD   = 3'd1,
    INSTR_SUB   = 3'd2,
    INSTR_OUT   = 3'd3,
    INSTR_HLT   = 3'd4,
    INSTR_UNDEF = 3'd5
  } instr_e;

  function automatic instr_e decode_opcode(input logic [3:0] op);
    instr_e r;
    case (op)
      OP_LDA:  r = INSTR_LDA;
      OP_ADD:  r = INSTR_ADD;
      OP_SUB:  r = INSTR_SUB;
      OP_OUT:  r = INSTR_OUT;
      OP_HLT:  r = INSTR_HLT;
      default: r = INSTR_UNDEF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ring_counter_6.sv
// ring_counter_6 -- one-hot T1..T6 ring, T6 wraps to T1.
// Ports:
//   clk      system clock
//   clr      synchronous clear, forces T1 (highest priority)
//   en       advance one position per clock when high
//   t_state  current one-hot position
// A non-one-hot value (e.g. after an upset) recovers to T1 on the next advance.
module ring_counter_6
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  output logic [5:0] t_state
);

  logic [5:0] t_q;
  logic [5:0] t_d;

  // Next ring position when enabled, otherwise hold.
  always_comb begin
    t_d = t_q;
    if (en) begin
      case (t_q)
        T1:      t_d = T2;
        T2:      t_d = T3;
        T3:      t_d = T4;
        T4:      t_d = T5;
        T5:      t_d = T6;
        T6:      t_d = T1;
        default: t_d = T1;
      endcase
    end else begin
      t_d = t_q;
    end
  end

  // Ring register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      t_q <= T1;
    end else begin
      t_q <= t_d;
    end
  end

  assign t_state = t_q;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer -- T-state sequencer and microcode decode for a SAP-style CPU.
// Ports:
//   clk, reset_n       clock; synchronous active-low reset (forces T1, clears HALT)
//   run                1 = advance, 0 = freeze state with all controls deasserted
//   opcode[3:0]        instruction opcode, decoded combinationally in T4-T6
//   pc_inc, alu_sub    active-high controls
//   *_out_n, *_in_n    active-low bus drive / register load enables
//   t_state[5:0]       one-hot T-state (zero while halted or in reset)
//   halted             high in the HALT state
// Parameter HALT_ON_UNDEF: 1 = undefined opcodes halt like HLT, 0 = they are NOPs.
// Controls are purely combinational from state, opcode, run and reset_n.
module control_sequencer
  import sap_pkg::*;
#(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_out_n,
  output logic       ram_out_n,
  output logic       ir_out_n,
  output logic       a_out_n,
  output logic       alu_out_n,
  output logic       mar_in_n,
  output logic       ir_in_n,
  output logic       a_in_n,
  output logic       b_in_n,
  output logic       out_in_n,
  output logic       alu_sub,
  output logic [5:0] t_state,
  output logic       halted
);

  logic [5:0] ring_t_s;
  logic       ring_en_s;
  logic       halt_req_s;
  logic       halt_entry_s;
  logic       halted_q;
  logic       halted_d;
  instr_e     instr_s;
  ctrl_word_t cw_s;

  ring_counter_6 u_ring (
    .clk     (clk),
    .clr     (~reset_n),
    .en      (ring_en_s),
    .t_state (ring_t_s)
  );

  // Opcode decode and HALT entry; the ring stops on the T4 that enters HALT.
  always_comb begin
    instr_s      = decode_opcode(opcode);
    halt_req_s   = (instr_s == INSTR_HLT) ||
                   (HALT_ON_UNDEF && (instr_s == INSTR_UNDEF));
    halt_entry_s = run && !halted_q && (ring_t_s == T4) && halt_req_s;
    ring_en_s    = run && !halted_q && !halt_entry_s;
    halted_d     = halted_q || halt_entry_s;
  end

  // HALT flag: sticky until reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Microcode: control word per T-state and instruction class.
  always_comb begin
    cw_s = {CW_W{1'b0}};
    if (reset_n && run && !halted_q) begin
      case (ring_t_s)
        T1: begin
          cw_s[CW_PC_OUT] = 1'b1;
          cw_s[CW_MAR_IN] = 1'b1;
        end
        T2: cw_s[CW_PC_INC] = 1'b1;
        T3: begin
          cw_s[CW_RAM_OUT] = 1'b1;
          cw_s[CW_IR_IN]   = 1'b1;
        end
        T4: begin
          case (instr_s)
            INSTR_LDA, INSTR_ADD, INSTR_SUB: begin
              cw_s[CW_IR_OUT] = 1'b1;
              cw_s[CW_MAR_IN] = 1'b1;
            end
            INSTR_OUT: begin
              cw_s[CW_A_OUT]  = 1'b1;
              cw_s[CW_OUT_IN] = 1'b1;
            end
            default: cw_s = {CW_W{1'b0}};
          endcase
        end
        T5: begin
          case (instr_s)
            INSTR_LDA: begin
              cw_s[CW_RAM_OUT] = 1'b1;
              cw_s[CW_A_IN]    = 1'b1;
            end
            INSTR_ADD, INSTR_SUB: begin
              cw_s[CW_RAM_OUT] = 1'b1;
              cw_s[CW_B_IN]    = 1'b1;
              cw_s[CW_ALU_SUB] = (instr_s == INSTR_SUB);
            end
            default: cw_s = {CW_W{1'b0}};
          endcase
        end
        T6: begin
          case (instr_s)
            INSTR_ADD, INSTR_SUB: begin
              cw_s[CW_ALU_OUT] = 1'b1;
              cw_s[CW_A_IN]    = 1'b1;
              cw_s[CW_ALU_SUB] = (instr_s == INSTR_SUB);
            end
            default: cw_s = {CW_W{1'b0}};
          endcase
        end
        default: cw_s = {CW_W{1'b0}};
      endcase
    end else begin
      cw_s = {CW_W{1'b0}};
    end
  end

  assign pc_inc    =  cw_s[CW_PC_INC];
  assign pc_out_n  = ~cw_s[CW_PC_OUT];
  assign ram_out_n = ~cw_s[CW_RAM_OUT];
  assign ir_out_n  = ~cw_s[CW_IR_OUT];
  assign a_out_n   = ~cw_s[CW_A_OUT];
  assign alu_out_n = ~cw_s[CW_ALU_OUT];
  assign mar_in_n  = ~cw_s[CW_MAR_IN];
  assign ir_in_n   = ~cw_s[CW_IR_IN];
  assign a_in_n    = ~cw_s[CW_A_IN];
  assign b_in_n    = ~cw_s[CW_B_IN];
  assign out_in_n  = ~cw_s[CW_OUT_IN];
  assign alu_sub   =  cw_s[CW_ALU_SUB];
  assign t_state   = (reset_n && !halted_q) ? ring_t_s : 6'b000000;
  assign halted    = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (HALT_ON_UNDEF = 0 and 1) share
// stimulus. A step-counter model predicts every output each cycle; directed
// sequences pin the model with hand-written expectations.
module tb_control_sequencer;

  localparam logic [11:0] K_PCI  = 12'h001;
  localparam logic [11:0] K_PCO  = 12'h002;
  localparam logic [11:0] K_RAMO = 12'h004;
  localparam logic [11:0] K_IRO  = 12'h008;
  localparam logic [11:0] K_AO   = 12'h010;
  localparam logic [11:0] K_ALUO = 12'h020;
  localparam logic [11:0] K_MARI = 12'h040;
  localparam logic [11:0] K_IRI  = 12'h080;
  localparam logic [11:0] K_AI   = 12'h100;
  localparam logic [11:0] K_BI   = 12'h200;
  localparam logic [11:0] K_OI   = 12'h400;
  localparam logic [11:0] K_SUB  = 12'h800;

  logic       clk;
  logic       reset_n;
  logic       run;
  logic [3:0] opcode;
  logic [1:0] pc_inc_v, pc_out_n_v, ram_out_n_v, ir_out_n_v, a_out_n_v, alu_out_n_v;
  logic [1:0] mar_in_n_v, ir_in_n_v, a_in_n_v, b_in_n_v, out_in_n_v, alu_sub_v, halted_v;
  logic [5:0] ts_v [2];

  int n_checks = 0;
  int n_fail   = 0;

  // model state per instance: position in the six-step instruction and halt flag
  int m_step [2];
  bit m_halt [2];
  int pc_cnt [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  control_sequencer #(.HALT_ON_UNDEF(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode),
    .pc_inc(pc_inc_v[0]), .pc_out_n(pc_out_n_v[0]), .ram_out_n(ram_out_n_v[0]),
    .ir_out_n(ir_out_n_v[0]), .a_out_n(a_out_n_v[0]), .alu_out_n(alu_out_n_v[0]),
    .mar_in_n(mar_in_n_v[0]), .ir_in_n(ir_in_n_v[0]), .a_in_n(a_in_n_v[0]),
    .b_in_n(b_in_n_v[0]), .out_in_n(out_in_n_v[0]), .alu_sub(alu_sub_v[0]),
    .t_state(ts_v[0]), .halted(halted_v[0])
  );

  control_sequencer #(.HALT_ON_UNDEF(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode),
    .pc_inc(pc_inc_v[1]), .pc_out_n(pc_out_n_v[1]), .ram_out_n(ram_out_n_v[1]),
    .ir_out_n(ir_out_n_v[1]), .a_out_n(a_out_n_v[1]), .alu_out_n(alu_out_n_v[1]),
    .mar_in_n(mar_in_n_v[1]), .ir_in_n(ir_in_n_v[1]), .a_in_n(a_in_n_v[1]),
    .b_in_n(b_in_n_v[1]), .out_in_n(out_in_n_v[1]), .alu_sub(alu_sub_v[1]),
    .t_state(ts_v[1]), .halted(halted_v[1])
  );

  task automatic chk(input string n, input logic [11:0] a, input logic [11:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%03h required=%03h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [11:0] act_cw(input int k);
    return {alu_sub_v[k], ~out_in_n_v[k], ~b_in_n_v[k], ~a_in_n_v[k], ~ir_in_n_v[k],
            ~mar_in_n_v[k], ~alu_out_n_v[k], ~a_out_n_v[k], ~ir_out_n_v[k],
            ~ram_out_n_v[k], ~pc_out_n_v[k], pc_inc_v[k]};
  endfunction

  function automatic bit m_halts(input logic [3:0] op, input bit hou);
    case (op)
      4'hF:                   return 1'b1;
      4'h0, 4'h1, 4'h2, 4'hE: return 1'b0;
      default:                return hou;
    endcase
  endfunction

  // Expected controls: fixed fetch steps, then a three-entry table per instruction.
  function automatic logic [11:0] exp_ctrl(input int step, input bit hlt, input bit r,
                                           input bit ru, input logic [3:0] op);
    logic [11:0] ph [3];
    if (!r || hlt || !ru) return 12'h000;
    case (op)
      4'h0:    ph = '{K_IRO | K_MARI, K_RAMO | K_AI, 12'h000};
      4'h1:    ph = '{K_IRO | K_MARI, K_RAMO | K_BI, K_ALUO | K_AI};
      4'h2:    ph = '{K_IRO | K_MARI, K_RAMO | K_BI | K_SUB, K_ALUO | K_AI | K_SUB};
      4'hE:    ph = '{K_AO | K_OI, 12'h000, 12'h000};
      default: ph = '{12'h000, 12'h000, 12'h000};
    endcase
    if (step == 0) return K_PCO | K_MARI;
    if (step == 1) return K_PCI;
    if (step == 2) return K_RAMO | K_IRI;
    return ph[step - 3];
  endfunction

  function automatic logic [5:0] exp_ts(input int step, input bit hlt, input bit r);
    logic [5:0] one;
    one = 6'b000001;
    if (!r || hlt) return 6'b000000;
    return one << step;
  endfunction

  // Model state update on each rising edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_step[k] <= 0;
        m_halt[k] <= 1'b0;
      end else if (!m_halt[k] && run) begin
        if (m_step[k] == 3 && m_halts(opcode, k == 1)) m_halt[k] <= 1'b1;
        else m_step[k] <= (m_step[k] + 1) % 6;
      end
    end
  end

  // Per-cycle comparison of both instances against the model, plus invariants.
  initial begin
    pc_cnt[0] = 0;
    pc_cnt[1] = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        int lows;
        chk($sformatf("model%0d_ctrl", k), act_cw(k),
            exp_ctrl(m_step[k], m_halt[k], reset_n, run, opcode));
        chk($sformatf("model%0d_tstate", k), {6'b000000, ts_v[k]},
            {6'b000000, exp_ts(m_step[k], m_halt[k], reset_n)});
        chk($sformatf("model%0d_halted", k), {11'b0, halted_v[k]}, {11'b0, m_halt[k]});
        lows = $countones({~pc_out_n_v[k], ~ram_out_n_v[k], ~ir_out_n_v[k],
                           ~a_out_n_v[k], ~alu_out_n_v[k]});
        chk($sformatf("inv%0d_one_driver", k), {11'b0, (lows <= 1)}, 12'h001);
        if (reset_n && run && ts_v[k] == 6'b000100) begin
          chk($sformatf("inv%0d_pc_inc_once", k), pc_cnt[k][11:0], 12'h001);
          pc_cnt[k] = 0;
        end
        if (!reset_n) pc_cnt[k] = 0;
        else if (pc_inc_v[k]) pc_cnt[k]++;
      end
    end
  end

  task automatic cyc(input bit r, input bit ru, input logic [3:0] op);
    @(posedge clk);
    #1;
    reset_n = r;
    run     = ru;
    opcode  = op;
    @(negedge clk);
  endtask

  task automatic ex(input string n, input int k, input logic [5:0] ts,
                    input logic [11:0] cw, input bit h);
    chk({n, "_ts"}, {6'b000000, ts_v[k]}, {6'b000000, ts});
    chk({n, "_cw"}, act_cw(k), cw);
    chk({n, "_h"}, {11'b0, halted_v[k]}, {11'b0, h});
  endtask

  initial begin
    int hc;
    bit r;
    bit ru;
    logic [3:0] op;
    reset_n = 1'b0;
    run     = 1'b0;
    opcode  = 4'h0;
    @(negedge clk);
    ex("reset", 0, 6'b000000, 12'h000, 1'b0);

    // LDA, then wrap to T1
    cyc(1'b1, 1'b1, 4'h0); ex("lda_t1", 0, 6'b000001, K_PCO | K_MARI, 1'b0);
    cyc(1'b1, 1'b1, 4'h0); ex("lda_t2", 0, 6'b000010, K_PCI, 1'b0);
    cyc(1'b1, 1'b1, 4'h0); ex("lda_t3", 0, 6'b000100, K_RAMO | K_IRI, 1'b0);
    cyc(1'b1, 1'b1, 4'h0); ex("lda_t4", 0, 6'b001000, K_IRO | K_MARI, 1'b0);
    cyc(1'b1, 1'b1, 4'h0); ex("lda_t5", 0, 6'b010000, K_RAMO | K_AI, 1'b0);
    cyc(1'b1, 1'b1, 4'h0); ex("lda_t6", 0, 6'b100000, 12'h000, 1'b0);
    // SUB
    cyc(1'b1, 1'b1, 4'h2); ex("sub_t1", 0, 6'b000001, K_PCO | K_MARI, 1'b0);
    cyc(1'b1, 1'b1, 4'h2); ex("sub_t2", 0, 6'b000010, K_PCI, 1'b0);
    cyc(1'b1, 1'b1, 4'h2); ex("sub_t3", 0, 6'b000100, K_RAMO | K_IRI, 1'b0);
    cyc(1'b1, 1'b1, 4'h2); ex("sub_t4", 0, 6'b001000, K_IRO | K_MARI, 1'b0);
    cyc(1'b1, 1'b1, 4'h2); ex("sub_t5", 0, 6'b010000, K_RAMO | K_BI | K_SUB, 1'b0);
    cyc(1'b1, 1'b1, 4'h2); ex("sub_t6", 0, 6'b100000, K_ALUO | K_AI | K_SUB, 1'b0);
    // OUT with a three-cycle stall in T2
    cyc(1'b1, 1'b1, 4'hE); ex("out_t1", 0, 6'b000001, K_PCO | K_MARI, 1'b0);
    cyc(1'b1, 1'b0, 4'hE); ex("stall0", 0, 6'b000010, 12'h000, 1'b0);
    cyc(1'b1, 1'b0, 4'hE); ex("stall1", 0, 6'b000010, 12'h000, 1'b0);
    cyc(1'b1, 1'b0, 4'hE); ex("stall2", 0, 6'b000010, 12'h000, 1'b0);
    cyc(1'b1, 1'b1, 4'hE); ex("out_t2", 0, 6'b000010, K_PCI, 1'b0);
    cyc(1'b1, 1'b1, 4'hE); ex("out_t3", 0, 6'b000100, K_RAMO | K_IRI, 1'b0);
    cyc(1'b1, 1'b1, 4'hE); ex("out_t4", 0, 6'b001000, K_AO | K_OI, 1'b0);
    cyc(1'b1, 1'b1, 4'hE); ex("out_t5", 0, 6'b010000, 12'h000, 1'b0);
    cyc(1'b1, 1'b1, 4'hE); ex("out_t6", 0, 6'b100000, 12'h000, 1'b0);
    // ADD interrupted by reset in T5
    cyc(1'b1, 1'b1, 4'h1); ex("add_t1", 0, 6'b000001, K_PCO | K_MARI, 1'b0);
    cyc(1'b1, 1'b1, 4'h1); ex("add_t2", 0, 6'b000010, K_PCI, 1'b0);
    cyc(1'b1, 1'b1, 4'h1); ex("add_t3", 0, 6'b000100, K_RAMO | K_IRI, 1'b0);
    cyc(1'b1, 1'b1, 4'h1); ex("add_t4", 0, 6'b001000, K_IRO | K_MARI, 1'b0);
    cyc(1'b1, 1'b1, 4'h1); ex("add_t5", 0, 6'b010000, K_RAMO | K_BI, 1'b0);
    cyc(1'b0, 1'b1, 4'h1); ex("add_rst", 0, 6'b000000, 12'h000, 1'b0);
    cyc(1'b1, 1'b1, 4'h1); ex("add_after", 0, 6'b000001, K_PCO | K_MARI, 1'b0);
    // HLT: halt after T4, hold 20 cycles regardless of run, leave only by reset
    cyc(1'b1, 1'b1, 4'hF); ex("hlt_t2", 0, 6'b000010, K_PCI, 1'b0);
    cyc(1'b1, 1'b1, 4'hF); ex("hlt_t3", 0, 6'b000100, K_RAMO | K_IRI, 1'b0);
    cyc(1'b1, 1'b1, 4'hF); ex("hlt_t4", 0, 6'b001000, 12'h000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, i[0], 4'hF);
      ex("hlt_hold", 0, 6'b000000, 12'h000, 1'b1);
    end
    cyc(1'b0, 1'b1, 4'hF); ex("hlt_rst", 0, 6'b000000, 12'h000, 1'b1);
    cyc(1'b1, 1'b1, 4'h0); ex("hlt_after", 0, 6'b000001, K_PCO | K_MARI, 1'b0);
    // undefined opcode 0101: NOP on dut0, halt on dut1
    cyc(1'b1, 1'b1, 4'h5); ex("u_t2", 1, 6'b000010, K_PCI, 1'b0);
    cyc(1'b1, 1'b1, 4'h5); ex("u_t3", 1, 6'b000100, K_RAMO | K_IRI, 1'b0);
    cyc(1'b1, 1'b1, 4'h5); ex("u0_t4", 0, 6'b001000, 12'h000, 1'b0);
    ex("u1_t4", 1, 6'b001000, 12'h000, 1'b0);
    cyc(1'b1, 1'b1, 4'h5); ex("u0_t5", 0, 6'b010000, 12'h000, 1'b0);
    ex("u1_halt", 1, 6'b000000, 12'h000, 1'b1);
    cyc(1'b1, 1'b1, 4'h5); ex("u0_t6", 0, 6'b100000, 12'h000, 1'b0);
    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 4'h0); ex("u1_after", 1, 6'b000001, K_PCO | K_MARI, 1'b0);

    // random opcodes, run and occasional reset; reset releases long halts
    hc = 0;
    for (int i = 0; i < 10000; i++) begin
      if (m_halt[0] || m_halt[1]) hc++;
      else hc = 0;
      r = (hc <= 4) && ($urandom_range(0, 299) != 0);
      if (!r) hc = 0;
      ru = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 15))
        0, 1, 2:    op = 4'h0;
        3, 4, 5:    op = 4'h1;
        6, 7, 8:    op = 4'h2;
        9, 10, 11:  op = 4'hE;
        12:         op = 4'hF;
        13:         op = 4'h5;
        default:    op = 4'($urandom_range(0, 15));
      endcase
      cyc(r, ru, op);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter HALT_ON_UNDEF, default 0: 1 means an undefined opcode halts the machine; 0 means it executes as NOP.
REQ-002 clk  input  1  system clock; all state changes on posedge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 run  input  1  1 = sequencer advances; 0 = freeze state, all controls deasserted.
REQ-005 opcode  input  4  upper nibble of the instruction register; stable from T4 through T6.
REQ-006 pc_inc  output  1  program counter increment, active high.
REQ-007 pc_out_n, ram_out_n, ir_out_n, a_out_n, alu_out_n  output  1 each  bus drive enables, active low.
REQ-008 mar_in_n, ir_in_n, a_in_n, b_in_n, out_in_n  output  1 each  register load enables, active low.
REQ-009 alu_sub  output  1  ALU subtract select, active high.
REQ-010 t_state  output  6  one-hot current T-state, bit0 = T1; all zero while halted.
REQ-011 halted  output  1  high while in the HALT state.

Function
REQ-012 States: T1..T6 in a ring plus HALT; T6 is followed by T1.
REQ-013 With run=1 the state advances one step per clk; with run=0 the state holds and every control output is deasserted (pc_inc=0, alu_sub=0, all *_n=1).
REQ-014 Any output not named for the current state SHALL be deasserted.
REQ-015 Fetch: T1 asserts pc_out_n and mar_in_n; T2 asserts pc_inc; T3 asserts ram_out_n and ir_in_n.
REQ-016 Opcodes: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111; opcode is decoded combinationally in T4-T6.
REQ-017 LDA: T4 asserts ir_out_n and mar_in_n; T5 asserts ram_out_n and a_in_n; T6 asserts nothing.
REQ-018 ADD: T4 asserts ir_out_n and mar_in_n; T5 asserts ram_out_n and b_in_n; T6 asserts alu_out_n and a_in_n.
REQ-019 SUB: same as ADD, with alu_sub=1 in T5 and T6.
REQ-020 OUT: T4 asserts a_out_n and out_in_n; T5 and T6 assert nothing.
REQ-021 HLT: T4 asserts nothing; the next clk enters HALT and halted=1.
REQ-022 HALT is left only by reset; run has no effect while halted.
REQ-023 Undefined opcode with HALT_ON_UNDEF=0: T4-T6 assert nothing.
REQ-024 Undefined opcode with HALT_ON_UNDEF=1: behaves as HLT.
REQ-025 Invariant: at most one *_out_n is low in any cycle, including during reset and run=0.
REQ-026 Invariant: pc_inc is high for exactly one cycle per instruction.
REQ-027 Controls are combinational from state, opcode and run; there is no added output register stage.

Reset
REQ-028 reset_n=0 at a posedge forces state T1 and halted=0, from any state including HALT and mid-instruction.
REQ-029 While reset_n=0, all controls are deasserted and t_state=000000.
REQ-030 The first cycle after reset release with run=1 is T1, with pc_out_n=0 and mar_in_n=0.
REQ-031 reset_n takes priority over run and HALT.

Structure
REQ-032 Shared package sap_pkg holds the opcode constants, the T-state one-hot constants and control-word field indices.
REQ-033 sap_pkg is reused by the PC, ALU and top level.
REQ-034 Sub-module ring_counter_6 holds the one-hot T1..T6 ring, with enable and synchronous clear inputs.
REQ-035 HALT logic and decode reside in control_sequencer.

Verification
REQ-036 Reset then run=1, opcode=0000: t_state 000001→000010→000100→001000→010000→100000→000001; pc_out_n/mar_in_n low in T1, pc_inc high in T2, ram_out_n/a_in_n low in T5.
REQ-037 opcode=0010 across a full cycle: b_in_n low in T5; alu_out_n and a_in_n low in T6; alu_sub=1 in T5-T6 only.
REQ-038 opcode=1111: halted=1 from the cycle after T4, t_state=000000, all controls deasserted for 20 cycles; reset_n=0 for one clk, then T1.
REQ-039 run=0 in T2 for 3 cycles: pc_inc=0 during the stall, t_state stays 000010; pc_inc=1 for exactly one cycle once run=1.
REQ-040 Reset asserted in T5 of ADD: next cycle all controls deasserted; after release, T1.
REQ-041 Random opcodes and run over 10k cycles with HALT_ON_UNDEF at 0 and at 1: the REQ-025 and REQ-026 invariants hold, and opcode 0101 produces a NOP or a halt respectively.
